// File: rtl/spi_target_pkg.sv
// Shared definitions for the tinyQV SPI peripherals: byte geometry,
// bit-counter width, responder state encoding and the default underrun byte.
package tinyqv_spi_pkg;

    localparam int SPI_BITS_PER_BYTE = 8;
    // Wide enough to hold the value SPI_BITS_PER_BYTE itself.
    localparam int SPI_BIT_CNT_W = $clog2(SPI_BITS_PER_BYTE + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_target_state_t;

    localparam logic [7:0] SPI_IDLE_BYTE_DEFAULT = 8'hFF;

    // Bit that goes on the wire first for a freshly loaded byte.
    function automatic logic first_tx_bit(input logic [7:0] b, input logic lsb);
        return lsb ? b[0] : b[7];
    endfunction

endpackage

// File: rtl/spi_target_if.sv
// CPU-side register handshake of the SPI responder.
// master = CPU / bus side, slave = spi_target.
interface spi_target_if;

    logic [7:0] data_in;
    logic       load;
    logic       rx_read;
    logic       clear_status;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_full;
    logic       busy;
    logic       overrun;
    logic       underrun;

    modport master (
        output data_in, load, rx_read, clear_status,
        input  rx_data, rx_valid, tx_full, busy, overrun, underrun
    );

    modport slave (
        input  data_in, load, rx_read, clear_status,
        output rx_data, rx_valid, tx_full, busy, overrun, underrun
    );

endinterface

// File: rtl/spi_target_sync.sv
// Multi-flop synchroniser followed by a registered edge detector.
// level/rise/fall all appear STAGES+1 clk cycles after the pin changes.
module spi_target_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_reg;
    logic              sync;
    logic              level_reg;
    logic              rise_reg;
    logic              fall_reg;

    assign sync = chain_reg[STAGES-1];

    // Synchroniser chain; the reset value matches the idle level of the pin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain_reg <= {STAGES{RESET_VAL}};
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], din};
        end
    end

    // Edge detector: delayed level plus one-cycle rise/fall pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_reg <= RESET_VAL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            level_reg <= sync;
            rise_reg  <= sync & ~level_reg;
            fall_reg  <= ~sync & level_reg;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 responder for tinyQV. All SPI pins are oversampled in clk.
// Optional feature macro: SPI_TARGET_LSB_FIRST_EN adds the lsb_first input,
// sampled at CS fall, selecting LSB-first shifting for the transaction.
module spi_target
    import tinyqv_spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic spi_sck,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
`ifdef SPI_TARGET_LSB_FIRST_EN
    input  logic lsb_first,
`endif
    spi_target_if.slave bus
);

    localparam logic [0:0] S_IDLE  = ST_IDLE;
    localparam logic [0:0] S_SHIFT = ST_SHIFT;
    localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = SPI_BIT_CNT_W'(SPI_BITS_PER_BYTE - 1);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain_reg;
    logic mosi_sync;

    logic [0:0]               state_reg;
    logic [SPI_BIT_CNT_W-1:0] bit_cnt_reg;
    logic [7:0]               tx_shift_reg;
    logic [7:0]               rx_shift_reg;
    logic [7:0]               hold_reg;
    logic                     tx_full_reg;
    logic                     reload_pend_reg;
    logic                     miso_reg;
    logic                     oe_reg;
    logic [7:0]               rx_data_reg;
    logic                     rx_valid_reg;
    logic                     overrun_reg;
    logic                     underrun_reg;

    logic       lsb_mode;
    logic       sck_fall_ok;
    logic       tx_load_evt;
    logic       capture_evt;
    logic [7:0] tx_src;
    logic [7:0] rx_next;
    logic [7:0] tx_shifted;

    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .rstn  (rstn),
        .din   (spi_sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rstn  (rstn),
        .din   (spi_cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // MOSI only needs synchronising; it is sampled on detected sck rises.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mosi_chain_reg <= '0;
        end else begin
            mosi_chain_reg <= {mosi_chain_reg[SYNC_STAGES-2:0], spi_mosi};
        end
    end
    assign mosi_sync = mosi_chain_reg[SYNC_STAGES-1];

`ifdef SPI_TARGET_LSB_FIRST_EN
    logic lsb_reg;

    // Bit order is latched at CS fall and frozen for the transaction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lsb_reg <= 1'b0;
        end else if (state_reg == S_IDLE && cs_fall) begin
            lsb_reg <= lsb_first;
        end
    end
    assign lsb_mode = (state_reg == S_IDLE) ? lsb_first : lsb_reg;
`else
    assign lsb_mode = 1'b0;
`endif

    // A fall pulse implies the settled level is already low.
    assign sck_fall_ok = sck_fall & ~sck_level;

    assign tx_src     = tx_full_reg ? hold_reg : IDLE_BYTE;
    assign rx_next    = lsb_mode ? {mosi_sync, rx_shift_reg[7:1]}
                                 : {rx_shift_reg[6:0], mosi_sync};
    assign tx_shifted = lsb_mode ? {1'b0, tx_shift_reg[7:1]}
                                 : {tx_shift_reg[6:0], 1'b0};

    // Shift register pulls from the holding register at CS fall and on the
    // first sck fall after each completed byte; CS rise has priority.
    assign tx_load_evt = (state_reg == S_IDLE && cs_fall) ||
                         (state_reg == S_SHIFT && !cs_rise && sck_fall_ok && reload_pend_reg);
    assign capture_evt = (state_reg == S_SHIFT) && !cs_rise && sck_rise &&
                         (bit_cnt_reg == LAST_BIT);

    // Transaction state machine: bit counting and the two shift registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= S_IDLE;
            bit_cnt_reg     <= '0;
            tx_shift_reg    <= '0;
            rx_shift_reg    <= '0;
            reload_pend_reg <= 1'b0;
            miso_reg        <= 1'b0;
            oe_reg          <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cs_fall) begin
                        state_reg       <= S_SHIFT;
                        bit_cnt_reg     <= '0;
                        tx_shift_reg    <= tx_src;
                        rx_shift_reg    <= '0;
                        reload_pend_reg <= 1'b0;
                        miso_reg        <= first_tx_bit(tx_src, lsb_mode);
                        oe_reg          <= 1'b1;
                    end
                end
                default: begin
                    if (cs_rise) begin
                        // Partial RX byte and unsent TX byte are dropped.
                        state_reg       <= S_IDLE;
                        bit_cnt_reg     <= '0;
                        reload_pend_reg <= 1'b0;
                        miso_reg        <= 1'b0;
                        oe_reg          <= 1'b0;
                    end else begin
                        if (sck_rise) begin
                            rx_shift_reg <= rx_next;
                            if (bit_cnt_reg == LAST_BIT) begin
                                bit_cnt_reg     <= '0;
                                reload_pend_reg <= 1'b1;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                        if (sck_fall_ok) begin
                            if (reload_pend_reg) begin
                                tx_shift_reg    <= tx_src;
                                miso_reg        <= first_tx_bit(tx_src, lsb_mode);
                                reload_pend_reg <= 1'b0;
                            end else begin
                                tx_shift_reg <= tx_shifted;
                                miso_reg     <= lsb_mode ? tx_shift_reg[1] : tx_shift_reg[6];
                            end
                        end
                    end
                end
            endcase
        end
    end

    // TX holding register; a load racing a shift-register load wins tx_full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_reg    <= '0;
            tx_full_reg <= 1'b0;
        end else begin
            if (bus.load) begin
                hold_reg    <= bus.data_in;
                tx_full_reg <= 1'b1;
            end else if (tx_load_evt) begin
                tx_full_reg <= 1'b0;
            end
        end
    end

    // RX byte hand-off to the CPU; a read in the capture cycle keeps the new byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            if (capture_evt) begin
                rx_data_reg  <= rx_next;
                rx_valid_reg <= 1'b1;
            end else if (bus.rx_read) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun_reg  <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            overrun_reg  <= (overrun_reg & ~bus.clear_status) |
                            (capture_evt & rx_valid_reg & ~bus.rx_read);
            underrun_reg <= (underrun_reg & ~bus.clear_status) |
                            (tx_load_evt & ~tx_full_reg);
        end
    end

    assign spi_miso     = miso_reg;
    assign spi_miso_oe  = oe_reg;
    assign bus.rx_data  = rx_data_reg;
    assign bus.rx_valid = rx_valid_reg;
    assign bus.tx_full  = tx_full_reg;
    assign bus.busy     = ~cs_level;
    assign bus.overrun  = overrun_reg;
    assign bus.underrun = underrun_reg;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a mode-0 host at clk/16 plus CPU strobes.
module tb_spi_target;

    logic clk = 1'b0;
    logic rstn;
    logic spi_sck, spi_cs_n, spi_mosi;
    logic spi_miso, spi_miso_oe;
`ifdef SPI_TARGET_LSB_FIRST_EN
    logic lsb_first;
`endif
    int checks = 0;
    int errors = 0;
    logic [7:0] got;

    spi_target_if bus ();

    spi_target dut (
        .clk         (clk),
        .rstn        (rstn),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
`ifdef SPI_TARGET_LSB_FIRST_EN
        .lsb_first   (lsb_first),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse_load(input logic [7:0] b);
        bus.data_in = b;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic pulse_read();
        bus.rx_read = 1'b1;
        tick();
        bus.rx_read = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_status = 1'b1;
        tick();
        bus.clear_status = 1'b0;
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        repeat (8) tick();
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        repeat (8) tick();
    endtask

    // Host shifts nbits of mosi_byte MSB first and samples miso before each
    // rising edge. read_cap pulses rx_read exactly in the capture cycle of
    // the 8th bit (pin edge + SYNC_STAGES flops + edge flop + FSM = 4 edges).
    task automatic xfer(input logic [7:0] mosi_byte, input int nbits,
                        input bit read_cap, output logic [7:0] miso_byte);
        miso_byte = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mosi_byte[7-i];
            miso_byte[7-i] = spi_miso;
            spi_sck = 1'b1;
            if (read_cap && i == 7) begin
                repeat (3) tick();
                bus.rx_read = 1'b1;
                tick();
                bus.rx_read = 1'b0;
                repeat (4) tick();
            end else begin
                repeat (8) tick();
            end
            spi_sck = 1'b0;
            repeat (8) tick();
        end
        $display("xfer mosi=%0h bits=%0d miso=%0h", mosi_byte, nbits, miso_byte);
    endtask

    initial begin
        rstn = 1'b0;
        spi_sck = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        bus.data_in = 8'h00;
        bus.load = 1'b0;
        bus.rx_read = 1'b0;
        bus.clear_status = 1'b0;
`ifdef SPI_TARGET_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        repeat (3) tick();

        // Reset state
        check("rst_miso", 8'(spi_miso), 8'h0);
        check("rst_oe", 8'(spi_miso_oe), 8'h0);
        check("rst_rx_valid", 8'(bus.rx_valid), 8'h0);
        check("rst_busy", 8'(bus.busy), 8'h0);
        rstn = 1'b1;
        repeat (4) tick();

        // Load A5, host sends 3C
        pulse_load(8'hA5);
        check("load_tx_full", 8'(bus.tx_full), 8'h1);
        cs_low();
        check("cs_busy", 8'(bus.busy), 8'h1);
        check("cs_oe", 8'(spi_miso_oe), 8'h1);
        check("cs_tx_full_clr", 8'(bus.tx_full), 8'h0);
        xfer(8'h3C, 8, 1'b0, got);
        check("b1_miso", got, 8'hA5);
        check("b1_rx_data", bus.rx_data, 8'h3C);
        check("b1_rx_valid", 8'(bus.rx_valid), 8'h1);
        check("b1_overrun", 8'(bus.overrun), 8'h0);
        check("b1_underrun_bndry", 8'(bus.underrun), 8'h1);
        cs_high();
        check("csh_busy", 8'(bus.busy), 8'h0);
        check("csh_oe", 8'(spi_miso_oe), 8'h0);
        pulse_read();
        check("read_clr_valid", 8'(bus.rx_valid), 8'h0);
        pulse_clear();
        check("clear_underrun", 8'(bus.underrun), 8'h0);

        // Two bytes in one CS without reading: overrun
        pulse_load(8'h5A);
        cs_low();
        pulse_load(8'hC3);
        check("2b_tx_full", 8'(bus.tx_full), 8'h1);
        xfer(8'h11, 8, 1'b0, got);
        check("2b_miso1", got, 8'h5A);
        check("2b_underrun1", 8'(bus.underrun), 8'h0);
        check("2b_tx_full_clr", 8'(bus.tx_full), 8'h0);
        xfer(8'h22, 8, 1'b0, got);
        check("2b_miso2", got, 8'hC3);
        check("2b_rx_data", bus.rx_data, 8'h22);
        check("2b_overrun", 8'(bus.overrun), 8'h1);
        cs_high();
        pulse_clear();
        check("2b_overrun_clr", 8'(bus.overrun), 8'h0);
        pulse_read();

        // No load: IDLE_BYTE and underrun
        cs_low();
        check("ur_flag", 8'(bus.underrun), 8'h1);
        check("ur_tx_full", 8'(bus.tx_full), 8'h0);
        xfer(8'h96, 8, 1'b0, got);
        check("ur_miso", got, 8'hFF);
        check("ur_rx_data", bus.rx_data, 8'h96);
        cs_high();
        pulse_read();
        pulse_clear();

        // CS abort after 5 bits, then a clean byte
        cs_low();
        xfer(8'hF0, 5, 1'b0, got);
        cs_high();
        check("abort_rx_valid", 8'(bus.rx_valid), 8'h0);
        cs_low();
        xfer(8'h81, 8, 1'b0, got);
        check("abort_rx_data", bus.rx_data, 8'h81);
        check("abort_rx_valid2", 8'(bus.rx_valid), 8'h1);
        cs_high();
        pulse_read();
        pulse_clear();

        // rx_read in the exact capture cycle of the second byte
        cs_low();
        xfer(8'h44, 8, 1'b0, got);
        xfer(8'h99, 8, 1'b1, got);
        check("rdcap_rx_valid", 8'(bus.rx_valid), 8'h1);
        check("rdcap_rx_data", bus.rx_data, 8'h99);
        check("rdcap_overrun", 8'(bus.overrun), 8'h0);
        cs_high();

        // Asynchronous reset mid-byte, then a normal transfer
        pulse_load(8'h77);
        cs_low();
        xfer(8'hAA, 4, 1'b0, got);
        rstn = 1'b0;
        #1;
        check("arst_rx_valid", 8'(bus.rx_valid), 8'h0);
        check("arst_rx_data", bus.rx_data, 8'h00);
        check("arst_underrun", 8'(bus.underrun), 8'h0);
        check("arst_busy", 8'(bus.busy), 8'h0);
        check("arst_oe", 8'(spi_miso_oe), 8'h0);
        spi_cs_n = 1'b1;
        spi_sck = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        repeat (4) tick();
        pulse_load(8'h5C);
        cs_low();
        xfer(8'hE7, 8, 1'b0, got);
        check("post_rst_miso", got, 8'h5C);
        check("post_rst_rx_data", bus.rx_data, 8'hE7);
        check("post_rst_rx_valid", 8'(bus.rx_valid), 8'h1);
        cs_high();
        pulse_read();

`ifdef SPI_TARGET_LSB_FIRST_EN
        // LSB first: 01 leaves bit0 first, host sees it as 80
        lsb_first = 1'b1;
        pulse_load(8'h01);
        cs_low();
        check("lsb_first_bit", 8'(spi_miso), 8'h1);
        xfer(8'h00, 8, 1'b0, got);
        check("lsb_miso", got, 8'h80);
        cs_high();
        lsb_first = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI responder (target/slave) peripheral for the tinyQV SoC. It is the counterpart of the existing SPI controller: an external SPI host drives SCK/CS/MOSI, and this block shifts bytes in and out. The CPU sees it through a byte-wide register handshake: write a TX byte, read an RX byte, poll status. All SPI inputs are oversampled in the system clock domain, so the block has a single clock domain.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser flops on spi_sck, spi_cs_n and spi_mosi (minimum 2).
- IDLE_BYTE, 8'hFF: byte shifted out when no TX byte is loaded (underrun).

Ports:
- clk  input  1  system clock; the only clock.
- rstn  input  1  asynchronous, active-low reset.
- spi_sck  input  1  host SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
- spi_cs_n  input  1  host chip select, active low, asynchronous.
- spi_mosi  input  1  host data out, asynchronous.
- spi_miso  output  1  target data out.
- spi_miso_oe  output  1  MISO output enable; high only while selected.
- data_in  input  8  TX byte from the CPU.
- load  input  1  one-cycle strobe; writes data_in into the TX holding register.
- rx_read  input  1  one-cycle strobe; CPU has consumed rx_data.
- clear_status  input  1  one-cycle strobe; clears the sticky overrun and underrun flags.
- rx_data  output  8  last complete received byte.
- rx_valid  output  1  rx_data holds an unread byte.
- tx_full  output  1  TX holding register is occupied.
- busy  output  1  synchronised spi_cs_n is low.
- overrun  output  1  sticky; an RX byte was lost.
- underrun  output  1  sticky; IDLE_BYTE was sent because the TX holding register was empty.

## Operation
- Synchroniser: spi_sck, spi_cs_n and spi_mosi each pass through SYNC_STAGES flops, then an edge-detect flop on sck and cs_n. Reset state of the sync chains: sck=0, cs_n=1.
- State machine:
  - IDLE: cs_n high. On the synchronised cs_n falling edge, go to SHIFT, set bit_cnt=0, and load the shift register.
  - SHIFT:
    - On each sck rising edge: shift mosi in and increment bit_cnt.
    - On each sck falling edge: present the next TX bit on miso.
    - When bit_cnt reaches 8 (on the rising edge): capture the RX byte, wrap bit_cnt to 0, and reload the TX shift register on the following falling edge.
    - On a cs_n rising edge: go to IDLE.
- TX shift register load, at cs_n fall or at each byte boundary:
  - If tx_full: take the holding register and clear tx_full.
  - Otherwise: take IDLE_BYTE and set underrun.
- load while tx_full=1 overwrites the holding register; there is no error.
- load in the same cycle as a shift-register load: the shift register takes the old holding value, and the holding register takes data_in with tx_full=1.
- RX capture sets rx_valid=1 and rx_data=byte.
  - If rx_valid was already 1 and rx_read is not asserted in that cycle: set overrun and overwrite rx_data.
  - rx_read in the same cycle as a capture: the new byte is kept, rx_valid stays 1, and overrun is not set.
  - rx_read with no capture clears rx_valid.
- CS deasserted mid-byte: the partial RX byte is discarded, bit_cnt resets, and the TX byte already in the shift register is lost (it is not returned to the holding register). spi_miso_oe drops in the cycle after the cs_n edge is detected.
- clear_status in the same cycle as a new overrun or underrun event: the flag ends up set.
- Bit order is MSB first, unless changed as described under Configuration.

## Timing
- Reset (asynchronous): spi_miso=0, spi_miso_oe=0, rx_data=0, rx_valid=0, tx_full=0, busy=0, overrun=0, underrun=0, state=IDLE, bit_cnt=0.
- Input latency: pin to edge-detect is SYNC_STAGES+1 clk cycles.
- rx_valid rises SYNC_STAGES+2 cycles after the 8th sck rising edge at the pin.
- spi_miso updates SYNC_STAGES+2 cycles after an sck falling edge, or after the cs_n falling edge for the first bit.
- Host requirements:
  - SCK high and low phases of at least SYNC_STAGES+3 clk cycles each.
  - First SCK rising edge at least SYNC_STAGES+3 clk cycles after CS falls.
- tx_full is 1 the cycle after load; it clears the cycle after the shift-register load.
- busy follows the synchronised cs_n, with a delay of SYNC_STAGES+1 cycles.

## Configuration
- SPI_TARGET_LSB_FIRST_EN:
  - When defined: adds an input port lsb_first (1 bit). When lsb_first=1, both shift directions are LSB first. lsb_first is sampled at the cs_n falling edge and held for the whole transaction.
  - When undefined: the port is absent and operation is fixed MSB first.

## Structure
- Shared package tinyqv_spi_pkg:
  - SPI_BITS_PER_BYTE=8.
  - Bit-count width localparam.
  - State enum spi_target_state_t {ST_IDLE, ST_SHIFT}.
  - IDLE_BYTE default constant.
- One sub-module, spi_target_sync: a SYNC_STAGES synchroniser plus rise/fall edge detect. It is instantiated for sck and cs_n; mosi uses the synchroniser only.

## Test plan
- Reset, then load 8'hA5, then host sends 8'h3C with clk=16x sck → miso shifts out A5 MSB first; rx_data=3C, rx_valid=1, tx_full=0, overrun=0.
- Two bytes 8'h11, 8'h22 in one CS with no rx_read → rx_data=22, overrun=1. clear_status → overrun=0.
- No load before the transfer → miso outputs FF; underrun=1; tx_full stays 0.
- CS rises after 5 bits, then a new CS carries full byte 8'h81 → rx_data=81; the partial byte never raises rx_valid.
- rx_read asserted in the exact capture cycle of the 2nd byte → rx_valid stays 1, rx_data=2nd byte, overrun=0.
- rstn pulsed low mid-byte → all outputs return to reset values immediately; the next full transfer works normally. With SPI_TARGET_LSB_FIRST_EN and lsb_first=1: load 8'h01 → miso's first bit=1.
